// File: rtl/rect_fill_sequencer_pkg.sv
// rect_fill_sequencer_pkg: shared widths, DRAW instruction layout and sequencer state encoding.
package rect_fill_sequencer_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int INSTRUCTION_WIDTH = 24;
  localparam int OPCODE_WIDTH = 3;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW = 3'd2;
  localparam int PLOT_BIT = 18;
  localparam int COLOUR_LSB = 15;
  localparam int Y_LSB = 8;
  localparam int X_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_FINISH
  } state_t;
  function automatic logic [INSTRUCTION_WIDTH-1:0] draw_instr(
    input logic [C_W-1:0] colour,
    input logic [Y_W-1:0] y,
    input logic [X_W-1:0] x
  );
    draw_instr = '0;
    draw_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] = OPCODE_DRAW;
    draw_instr[PLOT_BIT] = 1'b1;
    draw_instr[COLOUR_LSB +: C_W] = colour;
    draw_instr[Y_LSB +: Y_W] = y;
    draw_instr[X_LSB +: X_W] = x;
  endfunction
endpackage

// File: rtl/rect_fill_sequencer_if.sv
// rect_fill_sequencer_if: rectangle request and datapath handshake bundle.
// req_outline exists only when RECT_OUTLINE_EN is defined.
interface rect_fill_sequencer_if;
  import rect_fill_sequencer_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic [X_W-1:0] req_w;
  logic [Y_W-1:0] req_h;
  logic [C_W-1:0] req_colour;
`ifdef RECT_OUTLINE_EN
  logic req_outline;
`endif
  logic busy;
  logic done;
  logic dp_start;
  logic [INSTRUCTION_WIDTH-1:0] dp_instruction;
  logic dp_finished;
  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour,
`ifdef RECT_OUTLINE_EN
    output req_outline,
`endif
    output dp_finished,
    input req_ready, busy, done, dp_start, dp_instruction
  );
  modport slave (
    input req_valid, req_x, req_y, req_w, req_h, req_colour,
`ifdef RECT_OUTLINE_EN
    input req_outline,
`endif
    input dp_finished,
    output req_ready, busy, done, dp_start, dp_instruction
  );
endinterface

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major 2-D offset counter (ox, oy) with clear, advance and last-pixel flag.
module rect_scan_counter
  import rect_fill_sequencer_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           clear,
  input  logic           advance,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] ox,
  output logic [Y_W-1:0] oy,
  output logic           last
);
  logic row_end;
  assign row_end = ox == w - X_W'(1);
  assign last = row_end & (oy == h - Y_W'(1));
  always_ff @(posedge clock)
    if (!resetn || clear) begin
      ox <= '0;
      oy <= '0;
    end else if (advance) begin
      ox <= row_end ? '0 : ox + X_W'(1);
      oy <= row_end ? oy + Y_W'(1) : oy;
    end
endmodule

// File: rtl/rect_fill_sequencer.sv
// rect_fill_sequencer: expands a rectangle request into clipped per-pixel DRAW instructions.
// Define RECT_OUTLINE_EN to add req_outline (border-only drawing).
module rect_fill_sequencer
  import rect_fill_sequencer_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic clock,
  input logic resetn,
  rect_fill_sequencer_if.slave bus
);
  localparam logic [X_W:0] MAX_X = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] MAX_Y = (Y_W + 1)'(SCREEN_H);
  state_t state, state_n;
  logic [X_W-1:0] rx, rw, ox;
  logic [Y_W-1:0] ry, rh, oy;
  logic [C_W-1:0] rc;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic busy_q, done_q, start_q;
  logic accept, clear, advance, last, border, drawable, issue;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
`ifdef RECT_OUTLINE_EN
  logic ro;
`endif
  rect_scan_counter u_scan (
    .clock,
    .resetn,
    .clear,
    .advance,
    .w(rw),
    .h(rh),
    .ox,
    .oy,
    .last
  );
  assign accept = bus.req_valid & bus.req_ready;
  // Extra MSB keeps origin+offset from wrapping back on screen
  assign px = {1'b0, rx} + {1'b0, ox};
  assign py = {1'b0, ry} + {1'b0, oy};
`ifdef RECT_OUTLINE_EN
  assign border = !ro | (ox == '0) | (ox == rw - X_W'(1)) | (oy == '0) | (oy == rh - Y_W'(1));
`else
  assign border = 1'b1;
`endif
  assign drawable = (px < MAX_X) & (py < MAX_Y) & border;
  assign issue = (state == S_ISSUE) & bus.dp_finished;
  assign bus.req_ready = (state == S_IDLE) & !busy_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dp_start = start_q;
  assign bus.dp_instruction = instr_q;
  always_comb begin
    state_n = state;
    clear = 1'b0;
    advance = 1'b0;
    case (state)
      S_IDLE: begin
        clear = accept;
        state_n = !accept ? S_IDLE : (bus.req_w == '0 || bus.req_h == '0) ? S_FINISH : S_SCAN;
      end
      S_SCAN: begin
        advance = !drawable;
        state_n = drawable ? S_ISSUE : last ? S_FINISH : S_SCAN;
      end
      S_ISSUE: state_n = bus.dp_finished ? S_WAIT_ACK : S_ISSUE;
      S_WAIT_ACK: state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        advance = bus.dp_finished;
        state_n = !bus.dp_finished ? S_WAIT_DONE : last ? S_FINISH : S_SCAN;
      end
      S_FINISH: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      start_q <= 1'b0;
      instr_q <= '0;
      rx <= '0;
      ry <= '0;
      rw <= '0;
      rh <= '0;
      rc <= '0;
`ifdef RECT_OUTLINE_EN
      ro <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done_q <= state == S_FINISH;
      // busy stays up through the done cycle and drops with it
      busy_q <= accept | (busy_q & !done_q);
      start_q <= issue;
      if (issue) instr_q <= draw_instr(rc, py[Y_W-1:0], px[X_W-1:0]);
      if (accept) begin
        rx <= bus.req_x;
        ry <= bus.req_y;
        rw <= bus.req_w;
        rh <= bus.req_h;
        rc <= bus.req_colour;
`ifdef RECT_OUTLINE_EN
        ro <= bus.req_outline;
`endif
      end
    end
endmodule

// File: tb/tb_rect_fill_sequencer.sv
// tb_rect_fill_sequencer: randomized and directed checks against a row-major pixel list model.
module tb_rect_fill_sequencer;
  import rect_fill_sequencer_pkg::*;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic fin = 1'b1;
  int cnt = 0;
  int accept_cnt = 0;
  int dbl = 0;
  int proto = 0;
  int checks = 0;
  int passes = 0;
  bit prev_start = 1'b0;
  logic [23:0] got_q[$];
  rect_fill_sequencer_if bus ();
  rect_fill_sequencer dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );
  assign bus.dp_finished = fin;
  always #5 clock = ~clock;
  // datapath model: drops finished on the edge it sees start, draws for 2 cycles
  always @(posedge clock)
    if (!resetn) begin
      fin <= 1'b1;
      cnt <= 0;
    end else if (bus.dp_start) begin
      fin <= 1'b0;
      cnt <= 2;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) fin <= 1'b1;
    end
  always @(posedge clock) begin
    prev_start <= resetn && bus.dp_start;
    if (resetn && bus.req_valid && bus.req_ready) accept_cnt <= accept_cnt + 1;
    if (resetn && bus.dp_start) begin
      got_q.push_back(bus.dp_instruction);
      if (prev_start) dbl <= dbl + 1;
      if (!fin) proto <= proto + 1;
    end
  end
  function automatic logic [23:0] pix(input int x, input int y, input int c);
    logic [2:0] cc;
    cc = c[2:0];
    return {OPCODE_DRAW, 2'b00, 1'b1, cc, 7'(y), 8'(x)};
  endfunction
  task automatic run_rect(input string name, input int x, input int y, input int w, input int h,
                          input int c, input int o, input bit hold, input int exp_lat);
    int a0, s0, lat, budget, bad;
    logic [23:0] exp_q[$];
    a0 = accept_cnt;
    s0 = got_q.size();
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        if (x + i < 160 && y + j < 120 && (o == 0 || i == 0 || i == w - 1 || j == 0 || j == h - 1))
          exp_q.push_back(pix(x + i, y + j, c));
    @(negedge clock);
    bus.req_x = 8'(x);
    bus.req_y = 7'(y);
    bus.req_w = 8'(w);
    bus.req_h = 7'(h);
    bus.req_colour = 3'(c);
`ifdef RECT_OUTLINE_EN
    bus.req_outline = o[0];
`endif
    bus.req_valid = 1'b1;
    lat = 0;
    budget = w * h * 8 + 20;
    while (!bus.done && lat < budget) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0)
          $display("FAIL %s busy_after_accept: busy=%b req_ready=%b, need 1/0", name, bus.busy, bus.req_ready);
        else passes++;
        if (!hold) bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1) $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
    else passes++;
    if (exp_lat >= 0) begin
      checks++;
      if (lat != exp_lat) $display("FAIL %s done_latency: got %0d cycles, need %0d", name, lat, exp_lat);
      else passes++;
    end
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL %s after_done: done=%b busy=%b ready=%b, need 0/0/1", name, bus.done, bus.busy, bus.req_ready);
    else passes++;
    checks++;
    if (accept_cnt - a0 != 1) $display("FAIL %s accepts: got %0d, need 1", name, accept_cnt - a0);
    else passes++;
    checks++;
    if (got_q.size() - s0 != exp_q.size())
      $display("FAIL %s instr_count: got %0d, need %0d", name, got_q.size() - s0, exp_q.size());
    else passes++;
    bad = -1;
    for (int k = 0; k < exp_q.size() && s0 + k < got_q.size(); k++)
      if (bad < 0 && got_q[s0+k] !== exp_q[k]) bad = k;
    checks++;
    if (bad >= 0) $display("FAIL %s instr[%0d]: got %h, need %h", name, bad, got_q[s0+bad], exp_q[bad]);
    else passes++;
    checks++;
    if (dbl != 0 || proto != 0) $display("FAIL %s dp_protocol: double_start=%0d start_while_busy=%0d, need 0/0", name, dbl, proto);
    else passes++;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.dp_start !== 1'b0 || bus.dp_instruction !== 24'h0)
      $display("FAIL reset_dp: dp_start=%b instr=%h, need 0/0", bus.dp_start, bus.dp_instruction);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_status: busy=%b done=%b, need 0/0", bus.busy, bus.done);
    else passes++;
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b, need 1", bus.req_ready);
    else passes++;
  endtask
  task automatic test_single;
    run_rect("single_1x1", 5, 7, 1, 1, 3, 0, 1'b0, -1);
  endtask
  task automatic test_fill;
    run_rect("fill_3x2", 0, 0, 3, 2, 6, 0, 1'b0, -1);
  endtask
  task automatic test_clip;
    run_rect("clip_corner", 158, 118, 4, 4, 1, 0, 1'b0, -1);
    run_rect("clip_full", 200, 10, 5, 3, 2, 0, 1'b0, -1);
  endtask
  task automatic test_empty;
    run_rect("empty_w0_hold", 10, 10, 0, 5, 4, 0, 1'b1, 2);
    run_rect("empty_h0", 10, 10, 4, 0, 4, 0, 1'b0, 2);
  endtask
`ifdef RECT_OUTLINE_EN
  task automatic test_outline;
    int s0, hit;
    s0 = got_q.size();
    run_rect("outline_3x3", 10, 10, 3, 3, 5, 1, 1'b0, -1);
    hit = 0;
    for (int k = s0; k < got_q.size(); k++) if (got_q[k] === pix(11, 11, 5)) hit++;
    checks++;
    if (hit != 0) $display("FAIL outline_interior: (11,11) issued %0d times, need 0", hit);
    else passes++;
  endtask
`endif
  task automatic test_random;
    int x, y, w, h, o;
    for (int n = 0; n < 25; n++) begin
      x = $urandom_range(0, 1) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 149));
      y = $urandom_range(0, 1) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 109));
      w = $urandom_range(0, 10);
      h = $urandom_range(0, 6);
`ifdef RECT_OUTLINE_EN
      o = $urandom_range(0, 1);
`else
      o = 0;
`endif
      run_rect($sformatf("random_%0d", n), x, y, w, h, $urandom_range(0, 7), o, 1'($urandom_range(0, 1)), -1);
    end
  endtask
  task automatic test_reset_mid;
    int n, s1;
    n = 0;
    @(negedge clock);
    bus.req_x = 8'd20;
    bus.req_y = 7'd20;
    bus.req_w = 8'd6;
    bus.req_h = 7'd4;
    bus.req_colour = 3'd5;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    while (bus.dp_start !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.dp_start !== 1'b1) $display("FAIL reset_mid_start: no dp_start within 100 cycles");
    else passes++;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.dp_start !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL reset_mid_abort: dp_start=%b busy=%b ready=%b, need 0/0/1", bus.dp_start, bus.busy, bus.req_ready);
    else passes++;
    resetn = 1'b1;
    s1 = got_q.size();
    repeat (20) @(negedge clock);
    checks++;
    if (got_q.size() != s1 || bus.busy !== 1'b0)
      $display("FAIL reset_mid_quiet: %0d starts after reset, busy=%b, need 0/0", got_q.size() - s1, bus.busy);
    else passes++;
    run_rect("after_reset", 5, 7, 1, 1, 3, 0, 1'b0, -1);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_w = '0;
    bus.req_h = '0;
    bus.req_colour = '0;
`ifdef RECT_OUTLINE_EN
    bus.req_outline = 1'b0;
`endif
    test_reset();
    test_single();
    test_fill();
    test_clip();
    test_empty();
`ifdef RECT_OUTLINE_EN
    test_outline();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
